// File: rtl/jvm_arm_pkg.sv
// Shared definitions for the JVM-bytecode to ARMv7 translator: default
// sizes, FSM state encoding, translation-table entry layout and opcodes.
package jvm_arm_pkg;

  localparam int unsigned D_OUT_ADR_W = 8;
  localparam int unsigned D_MAX_OPND  = 4;
  localparam int unsigned D_MAX_EMIT  = 4;

  // Counter widths able to hold 0..MAX inclusive.
  localparam int unsigned OPND_CNT_W = $clog2(D_MAX_OPND + 1);
  localparam int unsigned EMIT_CNT_W = $clog2(D_MAX_EMIT + 1);

  localparam logic [7:0] OP_NOP    = 8'h00;
  localparam logic [7:0] OP_BIPUSH = 8'h10;
  localparam logic [7:0] OP_SIPUSH = 8'h11;

  typedef enum logic [1:0] {
    ST_OPCODE,
    ST_OPERAND,
    ST_EMIT,
    ST_HALT
  } state_e;

  // One translation-table entry; n_emit==0 marks an illegal opcode.
  // mask[k] set means operand bits [11:0] are OR-ed into tmpl[k].
  typedef struct packed {
    logic [OPND_CNT_W-1:0]           n_opnd;
    logic [EMIT_CNT_W-1:0]           n_emit;
    logic [D_MAX_EMIT-1:0]           mask;
    logic [D_MAX_EMIT-1:0][31:0]     tmpl;
  } tbl_entry_t;

endpackage

// File: rtl/bytecode_translator_if.sv
// Byte-in / word-out handshake bundle of the bytecode translator.
interface bytecode_translator_if #(
  parameter int unsigned OUT_ADR_W = jvm_arm_pkg::D_OUT_ADR_W
) ();

  logic                 in_valid;
  logic [7:0]           in_data;
  logic                 in_ready;
  logic                 out_valid;
  logic [OUT_ADR_W-1:0] out_adr;
  logic [31:0]          out_data;
  logic                 out_ready;

  // Translator side.
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_adr, out_data
  );

  // Byte source / word sink side.
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_adr, out_data
  );

endinterface

// File: rtl/bc_table.sv
// Combinational translation ROM: opcode -> operand count, word count,
// insert mask and ARMv7 template words. All ARM encodings live here.
module bc_table
  import jvm_arm_pkg::*;
(
  input  logic [7:0] opcode_i,
  output tbl_entry_t entry_o
);

  // Table lookup; unlisted opcodes keep n_emit==0 (illegal).
  always_comb begin
    entry_o = '0;
    unique case (opcode_i)
      OP_NOP: begin
        entry_o.n_opnd  = OPND_CNT_W'(0);
        entry_o.n_emit  = EMIT_CNT_W'(1);
        entry_o.tmpl[0] = 32'hE1A0_0000;              // mov r0, r0
      end
      OP_BIPUSH: begin
        entry_o.n_opnd  = OPND_CNT_W'(1);
        entry_o.n_emit  = EMIT_CNT_W'(2);
        entry_o.mask    = 4'b0001;
        entry_o.tmpl[0] = 32'hE3A0_0000;              // mov r0, #imm8
        entry_o.tmpl[1] = 32'hE52D_0004;              // push {r0}
      end
      OP_SIPUSH: begin
        entry_o.n_opnd  = OPND_CNT_W'(2);
        entry_o.n_emit  = EMIT_CNT_W'(2);
        entry_o.mask    = 4'b0001;
        entry_o.tmpl[0] = 32'hE300_0000;              // movw r0, #imm12
        entry_o.tmpl[1] = 32'hE52D_0004;              // push {r0}
      end
      default: entry_o = '0;
    endcase
  end

endmodule

// File: rtl/bytecode_translator.sv
// Streams JVM bytecodes in one byte at a time and writes the translated
// ARMv7 words to consecutive output-RAM addresses.
module bytecode_translator
  import jvm_arm_pkg::*;
#(
  parameter int unsigned OUT_ADR_W = D_OUT_ADR_W,
  parameter int unsigned MAX_OPND  = D_MAX_OPND,
  parameter int unsigned MAX_EMIT  = D_MAX_EMIT
) (
  input  logic                 clk,
  input  logic                 reset,
  bytecode_translator_if.slave bus,
  output logic                 err,
  output logic                 wrap,
  output logic                 busy
);

  localparam int unsigned OPND_W = 8 * MAX_OPND;
  localparam int unsigned K_W    = (MAX_EMIT > 1) ? $clog2(MAX_EMIT) : 1;

  state_e                 state_q, state_d;
  logic                   run_q;
  logic [7:0]             opcode_q, opcode_d;
  logic [OPND_W-1:0]      opnd_q, opnd_d;
  logic [OPND_CNT_W-1:0]  cnt_q, cnt_d;
  logic [K_W-1:0]         k_q, k_d;
  logic [OUT_ADR_W-1:0]   adr_q, adr_d;
  logic                   err_q, err_d;
  logic                   wrap_q, wrap_d;

  logic [7:0]             tbl_idx;
  tbl_entry_t             ent;
  logic                   in_rdy, out_vld, in_fire, out_fire, last_word;
  logic [31:0]            word;

  // In OPCODE the incoming byte is decoded directly so the next state is
  // known at the accepting edge; afterwards the latched opcode is used.
  assign tbl_idx = (state_q == ST_OPCODE) ? bus.in_data : opcode_q;

  bc_table u_table (
    .opcode_i (tbl_idx),
    .entry_o  (ent)
  );

  // run_q keeps in_ready low until the first edge after reset releases.
  assign in_rdy    = run_q && ((state_q == ST_OPCODE) || (state_q == ST_OPERAND));
  assign out_vld   = (state_q == ST_EMIT);
  assign in_fire   = bus.in_valid && in_rdy;
  assign out_fire  = out_vld && bus.out_ready;
  assign last_word = (EMIT_CNT_W'(k_q) == (ent.n_emit - 1'b1));

  // Current output word: template, optionally with the 12-bit operand inserted.
  always_comb begin
    word = ent.tmpl[k_q];
    if (ent.mask[k_q]) begin
      word = word | {20'b0, opnd_q[11:0]};
    end
  end

  assign bus.in_ready  = in_rdy;
  assign bus.out_valid = out_vld;
  assign bus.out_adr   = adr_q;
  assign bus.out_data  = out_vld ? word : '0;
  assign err           = err_q;
  assign wrap          = wrap_q;
  assign busy          = (state_q != ST_OPCODE);

  // Next-state and datapath update for the four-state translation FSM.
  always_comb begin
    state_d  = state_q;
    opcode_d = opcode_q;
    opnd_d   = opnd_q;
    cnt_d    = cnt_q;
    k_d      = k_q;
    adr_d    = adr_q;
    err_d    = err_q;
    wrap_d   = wrap_q;
    unique case (state_q)
      ST_OPCODE: begin
        if (in_fire) begin
          opcode_d = bus.in_data;
          opnd_d   = '0;
          cnt_d    = '0;
          k_d      = '0;
          if (ent.n_emit == '0) begin
            state_d = ST_HALT;
            err_d   = 1'b1;
          end else if (ent.n_opnd != '0) begin
            state_d = ST_OPERAND;
          end else begin
            state_d = ST_EMIT;
          end
        end
      end
      ST_OPERAND: begin
        if (in_fire) begin
          opnd_d = {opnd_q[OPND_W-9:0], bus.in_data};
          cnt_d  = cnt_q + 1'b1;
          if ((cnt_q + 1'b1) == ent.n_opnd) begin
            state_d = ST_EMIT;
          end
        end
      end
      ST_EMIT: begin
        if (out_fire) begin
          adr_d = adr_q + 1'b1;
          if (adr_q == '1) begin
            wrap_d = 1'b1;
          end
          if (last_word) begin
            k_d     = '0;
            state_d = ST_OPCODE;
          end else begin
            k_d = k_q + 1'b1;
          end
        end
      end
      ST_HALT: begin
        state_d = ST_HALT;
      end
      default: state_d = ST_HALT;
    endcase
  end

  // State and datapath registers; reset drops any partial bytecode.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_OPCODE;
      opcode_q <= '0;
      opnd_q   <= '0;
      cnt_q    <= '0;
      k_q      <= '0;
      adr_q    <= '0;
      err_q    <= 1'b0;
      wrap_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      opcode_q <= opcode_d;
      opnd_q   <= opnd_d;
      cnt_q    <= cnt_d;
      k_q      <= k_d;
      adr_q    <= adr_d;
      err_q    <= err_d;
      wrap_q   <= wrap_d;
    end
  end

  // Input-enable flag that rises on the first edge after reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      run_q <= 1'b0;
    end else begin
      run_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_bytecode_translator.sv
// Scoreboard bench for bytecode_translator: the driver pushes expected
// words from a reference translation model, a monitor pops and compares.
module tb_bytecode_translator;
  import jvm_arm_pkg::*;

  localparam int unsigned W = 8;

  logic clk = 1'b0;
  logic reset;
  logic err, wrap, busy;

  bytecode_translator_if #(.OUT_ADR_W(W)) bus ();

  bytecode_translator #(
    .OUT_ADR_W (W),
    .MAX_OPND  (4),
    .MAX_EMIT  (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .err   (err),
    .wrap  (wrap),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] adr;
    logic [31:0]  data;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk    = 0;
  int   n_fail   = 0;
  int   exp_adr  = 0;
  int   rdy_mode = 0;   // 0: sink stalls, 1: always ready, 2: random

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Reference model: what each bytecode must translate to.
  task automatic push_word(input logic [31:0] d);
    exp_t e;
    e.adr  = W'(exp_adr % (1 << W));
    e.data = d;
    exp_q.push_back(e);
    exp_adr++;
  endtask

  task automatic model(input logic [7:0] op, input logic [7:0] b0, input logic [7:0] b1);
    int v;
    case (op)
      8'h00: push_word(32'hE1A00000);
      8'h10: begin
        push_word(32'hE3A00000 + 32'(b0));
        push_word(32'hE52D0004);
      end
      8'h11: begin
        v = (int'(b0) * 256 + int'(b1)) % 4096;
        push_word(32'hE3000000 + 32'(v));
        push_word(32'hE52D0004);
      end
      default: ;
    endcase
  endtask

  // Sink ready generator.
  initial begin
    bus.out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       bus.out_ready = 1'b0;
        1:       bus.out_ready = 1'b1;
        default: bus.out_ready = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  // Monitor: compare each transferred word, and hold-stability while stalled.
  logic         stalled = 1'b0;
  logic [W-1:0] s_adr;
  logic [31:0]  s_data;
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset) begin
        stalled = 1'b0;
      end else if (!bus.out_valid) begin
        if (stalled) begin
          n_chk++;
          n_fail++;
          $display("FAIL valid_dropped: out_valid=0 during stall, expected 1");
        end
        stalled = 1'b0;
      end else begin
        if (stalled) begin
          check("hold_adr", 64'(bus.out_adr), 64'(s_adr));
          check("hold_data", 64'(bus.out_data), 64'(s_data));
        end
        if (bus.out_ready) begin
          stalled = 1'b0;
          if (exp_q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_word: got %0h @%0h, expected none", bus.out_data, bus.out_adr);
          end else begin
            e = exp_q.pop_front();
            check("word_adr", 64'(bus.out_adr), 64'(e.adr));
            check("word_data", 64'(bus.out_data), 64'(e.data));
          end
        end else begin
          stalled = 1'b1;
          s_adr   = bus.out_adr;
          s_data  = bus.out_data;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic send_byte(input logic [7:0] b);
    logic acc;
    int   t;
    t = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    do begin
      @(negedge clk);
      acc = bus.in_ready;
      step();
      t++;
    end while (!acc && t < 300);
    bus.in_valid = 1'b0;
    if (!acc) check("in_accept_timeout", 64'(acc), 64'd1);
  endtask

  task automatic issue(input logic [7:0] op, input logic [7:0] b0, input logic [7:0] b1);
    model(op, b0, b1);
    send_byte(op);
    if (op == 8'h10) send_byte(b0);
    if (op == 8'h11) begin
      send_byte(b0);
      send_byte(b1);
    end
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 3000) begin
      step();
      t++;
    end
    if (exp_q.size() != 0) check("drain_timeout", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic wait_out_valid();
    int t;
    t = 0;
    while (!bus.out_valid && t < 100) begin
      step();
      t++;
    end
    if (!bus.out_valid) check("out_valid_timeout", 64'(bus.out_valid), 64'd1);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    check("rst_in_ready", 64'(bus.in_ready), 64'd0);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_out_adr", 64'(bus.out_adr), 64'd0);
    check("rst_out_data", 64'(bus.out_data), 64'd0);
    check("rst_err_wrap_busy", 64'({err, wrap, busy}), 64'd0);
    exp_q.delete();
    exp_adr = 0;
    reset   = 1'b0;
    @(negedge clk);
    check("in_ready_before_edge", 64'(bus.in_ready), 64'd0);
    step();
    check("in_ready_after_edge", 64'(bus.in_ready), 64'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic any_rdy;
    int   t;
    logic [7:0] op;
    reset        = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    step();

    // NOP with latency and busy checks.
    rdy_mode = 1;
    do_reset();
    issue(OP_NOP, 8'h00, 8'h00);
    check("nop_latency_valid", 64'(bus.out_valid), 64'd1);
    check("nop_busy", 64'(busy), 64'd1);
    step();
    check("nop_busy_clear", 64'(busy), 64'd0);

    // BIPUSH 0x2A back to back.
    issue(OP_BIPUSH, 8'h2A, 8'h00);
    wait_drain();

    // SIPUSH with a stalled sink.
    rdy_mode = 0;
    step();
    issue(OP_SIPUSH, 8'h01, 8'h23);
    wait_out_valid();
    check("sipush_word0", 64'(bus.out_data), 64'hE3000123);
    repeat (3) step();
    rdy_mode = 1;
    wait_drain();

    // Illegal opcode halts the block.
    send_byte(8'hFF);
    step();
    check("illegal_err", 64'(err), 64'd1);
    check("illegal_busy", 64'(busy), 64'd1);
    any_rdy      = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h00;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      any_rdy = any_rdy | bus.in_ready | bus.out_valid;
      step();
    end
    bus.in_valid = 1'b0;
    check("halt_no_handshake", 64'(any_rdy), 64'd0);
    do_reset();
    issue(OP_NOP, 8'h00, 8'h00);
    wait_drain();
    check("err_cleared", 64'(err), 64'd0);

    // Reset right after the first BIPUSH word transfers.
    rdy_mode = 0;
    step();
    issue(OP_BIPUSH, 8'h2A, 8'h00);
    wait_out_valid();
    rdy_mode = 1;
    t = 0;
    while (exp_q.size() != 1 && t < 100) begin
      step();
      t++;
    end
    check("first_word_taken", 64'(exp_q.size()), 64'd1);
    reset = 1'b1;
    do_reset();
    issue(OP_NOP, 8'h00, 8'h00);
    wait_drain();

    // Address wrap after 2^W words.
    do_reset();
    for (int i = 0; i < (1 << W) - 1; i++) issue(OP_NOP, 8'h00, 8'h00);
    wait_drain();
    check("wrap_not_yet", 64'(wrap), 64'd0);
    issue(OP_NOP, 8'h00, 8'h00);
    wait_drain();
    check("wrap_set", 64'(wrap), 64'd1);
    issue(OP_NOP, 8'h00, 8'h00);
    wait_drain();
    check("wrap_sticky", 64'(wrap), 64'd1);

    // Random legal bytecodes, random gaps and random sink stalls.
    do_reset();
    rdy_mode = 2;
    for (int i = 0; i < 80; i++) begin
      case ($urandom_range(0, 2))
        0:       op = OP_NOP;
        1:       op = OP_BIPUSH;
        default: op = OP_SIPUSH;
      endcase
      repeat ($urandom_range(0, 2)) step();
      issue(op, 8'($urandom), 8'($urandom));
    end
    rdy_mode = 1;
    wait_drain();
    check("queue_empty", 64'(exp_q.size()), 64'd0);
    check("rand_no_err", 64'(err), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/bytecode_translator.md
BYTECODE_TRANSLATOR -- requirements
Module: bytecode_translator

Interface
REQ-001 The block SHALL have parameter OUT_ADR_W, default 8, the output-RAM address width.
REQ-002 The block SHALL have parameter MAX_OPND, default 4, the maximum operand bytes per bytecode.
REQ-003 The block SHALL have parameter MAX_EMIT, default 4, the maximum ARMv7 words emitted per bytecode.
REQ-004 Port: clk  in  1  the single clock; all state is clocked on its rising edge.
REQ-005 Port: reset  in  1  reset, asynchronous and active-high.
REQ-006 Port: in_valid  in  1  in_data holds a bytecode byte.
REQ-007 Port: in_data  in  8  bytecode stream byte, either an opcode or an operand.
REQ-008 Port: in_ready  out  1  the block accepts a byte this cycle.
REQ-009 Port: out_valid  out  1  out_adr/out_data hold a word to write.
REQ-010 Port: out_adr  out  OUT_ADR_W  output-RAM word address.
REQ-011 Port: out_data  out  32  ARMv7 instruction word.
REQ-012 Port: out_ready  in  1  the sink accepts the word this cycle.
REQ-013 Port: err  out  1  sticky flag for an illegal opcode.
REQ-014 Port: wrap  out  1  sticky flag set when out_adr wraps.
REQ-015 Port: busy  out  1  the FSM is in a state other than OPCODE.

Function
REQ-016 The FSM SHALL have exactly four states: OPCODE, OPERAND, EMIT and HALT.
REQ-017 A byte SHALL transfer on in_valid&&in_ready, and a word SHALL transfer on out_valid&&out_ready.
REQ-018 in_ready SHALL be 1 only in OPCODE and OPERAND, and out_valid SHALL be 1 only in EMIT.
REQ-019 In OPCODE, an accepted byte SHALL be latched as the opcode, and the table entry SHALL supply n_opnd (0..MAX_OPND), n_emit (0..MAX_EMIT), the template words T[0..MAX_EMIT-1] and the insert mask M.
REQ-020 If n_emit==0 (illegal opcode), the FSM SHALL go to HALT and set err on the next edge.
REQ-021 Otherwise, if n_opnd>0 the FSM SHALL go to OPERAND, else to EMIT.
REQ-022 In OPERAND, each accepted byte SHALL shift into the operand register big-endian: opnd <= {opnd[8*MAX_OPND-9:0], in_data}.
REQ-023 After the n_opnd-th operand byte, the FSM SHALL go to EMIT.
REQ-024 The operand register SHALL be cleared on each opcode acceptance.
REQ-025 Operand values SHALL be unsigned; sign handling is encoded in the templates.
REQ-026 In EMIT, word k SHALL be out_data = M[k] ? (T[k] | {20'b0, opnd[11:0]}) : T[k].
REQ-027 k SHALL start at 0 and advance on each transfer; after word n_emit-1 transfers, the FSM SHALL return to OPCODE.
REQ-028 out_valid, out_adr and out_data SHALL stay stable while out_ready is 0.
REQ-029 out_adr SHALL increment by 1 per transferred word, modulo 2^OUT_ADR_W.
REQ-030 When out_adr increments from all-ones to 0, wrap SHALL set and stay set until reset.
REQ-031 Latency SHALL be: opcode accepted at edge N gives the first out_valid in cycle N+1 when n_opnd==0; each operand byte adds one cycle minimum.
REQ-032 Peak throughput SHALL be one byte or one word per cycle.
REQ-033 In OPCODE and OPERAND the FSM SHALL wait with no timeout while in_valid is 0.
REQ-034 HALT SHALL be terminal: in_ready=0, out_valid=0, busy=1, exited only by reset.

Reset
REQ-035 While reset is 1: state=OPCODE, out_adr=0, out_data=0, out_valid=0, in_ready=0, err=0, wrap=0, busy=0, k=0, opnd=0.
REQ-036 in_ready SHALL rise on the first edge after reset falls.
REQ-037 A reset in any state, including mid-EMIT or mid-OPERAND, SHALL drop any partial bytecode, and no further words from it SHALL be emitted.

Structure
REQ-038 Package jvm_arm_pkg SHALL hold the state encoding, the default parameter values, the table-entry field layout (n_opnd, n_emit, M, T[]) and opcode constants (NOP=8'h00, BIPUSH=8'h10, SIPUSH=8'h11).
REQ-039 Sub-module bc_table SHALL be a combinational ROM indexed by the 8-bit opcode, returning one table entry.
REQ-040 bc_table SHALL be the only place ARM encodings live.
REQ-041 The table SHALL define: NOP = 0 operands, 1 word E1A00000.
REQ-042 The table SHALL define: BIPUSH = 1 operand, words E3A00000 (masked) and E52D0004.
REQ-043 The table SHALL define: SIPUSH = 2 operands, words E3000000 (masked) and E52D0004.
REQ-044 Every other opcode SHALL have n_emit=0.

Verification
REQ-045 Reset, then NOP with out_ready=1 -> cycle+1: out_adr=0, out_data=E1A00000; busy returns to 0.
REQ-046 BIPUSH, 0x2A -> words E3A0002A @0 and E52D0004 @1.
REQ-047 SIPUSH, 0x01, 0x23 -> first word E3000123; with out_ready held 0 for 3 cycles, outputs stay stable until accepted.
REQ-048 Opcode 0xFF -> err=1, in_ready=0 permanently; reset clears err and restores operation.
REQ-049 2^OUT_ADR_W+1 NOPs -> last word at out_adr=0, wrap=1.
REQ-050 Reset asserted after the first BIPUSH word transfers -> no E52D0004 word; next NOP written at out_adr=0.
